// File: rtl/eq_stream_checker_pkg.sv
// Shared types and default parameters for the eq_stream_checker slice.
// Optional macro EQ_STREAM_CHECKER_MASK_EN adds a per-bit compare mask to the top.
package eq_pkg;

  localparam int EQ_WIDTH_DEF = 8;
  localparam int EQ_DEPTH_DEF = 4;
  localparam int EQ_CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } eq_state_t;

endpackage

// File: rtl/eq_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and a show-ahead head word.
// Push is ignored when full and pop is ignored when empty, so it cannot over/underflow.
module eq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/eq_stream_checker.sv
// Pairs words from two independent valid/ready streams and reports equality per pair,
// with statistics and an optional halt-on-mismatch. Macro: EQ_STREAM_CHECKER_MASK_EN.
module eq_stream_checker
  import eq_pkg::*;
#(
  parameter int WIDTH = EQ_WIDTH_DEF,
  parameter int DEPTH = EQ_DEPTH_DEF,
  parameter int CNT_W = EQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             stop_en,
  input  logic             clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_eq,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_mis_vld,
  output logic [CNT_W-1:0] first_mis_idx,
  output logic             halted
`ifdef EQ_STREAM_CHECKER_MASK_EN
  ,
  input  logic [WIDTH-1:0] cmp_mask
`endif
);

  eq_state_t        state;
  logic [WIDTH-1:0] a_head, b_head, mask;
  logic             a_full, a_empty, b_full, b_empty;
  logic             running, pop, eq_w;
  logic [CNT_W-1:0] pair_idx;

`ifdef EQ_STREAM_CHECKER_MASK_EN
  assign mask = cmp_mask;
`else
  assign mask = '1;
`endif

  assign running = (state == RUN);
  assign a_ready = !a_full && running;
  assign b_ready = !b_full && running;
  assign pop     = !a_empty && !b_empty && running && (!res_valid || res_ready);
  assign eq_w    = (((a_head ^ b_head) & mask) == '0);

  eq_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_valid && a_ready),
    .push_data (a_data),
    .pop       (pop),
    .head      (a_head),
    .full      (a_full),
    .empty     (a_empty)
  );

  eq_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_valid && b_ready),
    .push_data (b_data),
    .pop       (pop),
    .head      (b_head),
    .full      (b_full),
    .empty     (b_empty)
  );

  // Result register: held until consumed, even while halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_eq    <= 1'b0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_eq    <= eq_w;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Statistics; clear takes priority over a simultaneous pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      pair_idx      <= '0;
      first_mis_vld <= 1'b0;
      first_mis_idx <= '0;
    end else if (pop) begin
      pair_idx <= pair_idx + 1'b1;
      if (eq_w) begin
        if (!(&match_cnt)) match_cnt <= match_cnt + 1'b1;
      end else begin
        if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (!first_mis_vld) begin
          first_mis_vld <= 1'b1;
          first_mis_idx <= pair_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: if (pop && !eq_w && stop_en) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_stream_checker.sv
// Directed bench for eq_stream_checker: stream drivers, a pairing model and a
// scoreboard of expected res_eq values checked on each result handshake.
module tb_eq_stream_checker;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, stop_en, clear, res_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_valid, b_valid, a_ready, b_ready;
  logic             res_valid, res_eq, first_mis_vld, halted;
  logic [CNT_W-1:0] match_cnt, mismatch_cnt, first_mis_idx;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] a_src[$], b_src[$], ma[$], mb[$];
  logic             exp_q[$];
  logic             a_en, b_en;

  always #5 clk = ~clk;

  eq_stream_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .a_data        (a_data),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .b_data        (b_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .stop_en       (stop_en),
    .clear         (clear),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_eq        (res_eq),
    .match_cnt     (match_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .first_mis_vld (first_mis_vld),
    .first_mis_idx (first_mis_idx),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive from source queues, score any result handshake, then
  // advance the model on accepted words.
  task automatic cyc();
    logic acc_a, acc_b;
    a_valid = a_en && (a_src.size() > 0);
    a_data  = a_valid ? a_src[0] : '0;
    b_valid = b_en && (b_src.size() > 0);
    b_data  = b_valid ? b_src[0] : '0;
    #1;
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
      else                   chk("res_eq", res_eq, exp_q.pop_front());
    end
    @(posedge clk);
    if (acc_a) ma.push_back(a_src.pop_front());
    if (acc_b) mb.push_back(b_src.pop_front());
    while (ma.size() > 0 && mb.size() > 0) begin
      logic [WIDTH-1:0] wa, wb;
      wa = ma.pop_front();
      wb = mb.pop_front();
      exp_q.push_back(wa == wb);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (exp_q.size() > 0 || a_src.size() > 0 || b_src.size() > 0
                               || ma.size() > 0 || mb.size() > 0); i++)
      cyc();
    chk("drain_done", (exp_q.size() == 0 && a_src.size() == 0 && b_src.size() == 0), 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    a_src.delete(); b_src.delete(); ma.delete(); mb.delete(); exp_q.delete();
  endtask

  initial begin
    stop_en = 1'b0; clear = 1'b0; res_ready = 1'b1;
    a_en = 1'b1; b_en = 1'b1; a_data = '0; b_data = '0;
    do_reset();
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_first_vld", first_mis_vld, 0);

    // Equal pairs, no stall; result one edge after the pair lands.
    a_src = '{8'd5, 8'd9, 8'd3}; b_src = '{8'd5, 8'd9, 8'd3};
    cyc();
    chk("lat_before", res_valid, 0);
    cyc();
    chk("lat_after", res_valid, 1);
    drain();
    chk("eq_match", match_cnt, 3);
    chk("eq_mismatch", mismatch_cnt, 0);
    chk("eq_first_vld", first_mis_vld, 0);

    // Halt on first mismatch, resume after clear.
    do_clear();
    stop_en = 1'b1;
    a_src = '{8'd1, 8'd2, 8'd3}; b_src = '{8'd1, 8'd7, 8'd3};
    repeat (8) cyc();
    chk("halt_halted", halted, 1);
    chk("halt_a_ready", a_ready, 0);
    chk("halt_b_ready", b_ready, 0);
    chk("halt_first_vld", first_mis_vld, 1);
    chk("halt_first_idx", first_mis_idx, 1);
    chk("halt_pending", exp_q.size(), 1);
    do_clear();
    stop_en = 1'b0;
    drain();
    chk("halt_resume_match", match_cnt, 1);
    chk("halt_resume_state", halted, 0);
    chk("halt_clear_vld", first_mis_vld, 0);

    // A runs DEPTH+2 ahead of B.
    do_clear();
    b_en = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      a_src.push_back(8'(8'h40 + i));
      b_src.push_back(8'(8'h40 + i));
    end
    repeat (8) cyc();
    chk("skew_a_ready", a_ready, 0);
    chk("skew_a_left", a_src.size(), 2);
    b_en = 1'b1;
    drain();
    chk("skew_match", match_cnt, DEPTH + 2);
    chk("skew_mismatch", mismatch_cnt, 0);

    // Result backpressure for 10 cycles; first pair mismatches.
    do_clear();
    res_ready = 1'b0;
    a_src = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    b_src = '{8'h12, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    repeat (2) cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", res_valid, 1);
      chk("bp_eq", res_eq, 0);
    end
    chk("bp_a_ready", a_ready, 0);
    chk("bp_b_ready", b_ready, 0);
    chk("bp_a_left", a_src.size(), 3);
    res_ready = 1'b1;
    drain();
    chk("bp_match", match_cnt, 7);
    chk("bp_mismatch", mismatch_cnt, 1);

    // Saturation and index wrap with CNT_W=4.
    do_clear();
    for (int i = 0; i < 20; i++) begin
      a_src.push_back(8'(i * 3));
      b_src.push_back(8'(i * 3));
    end
    a_src.push_back(8'hAA); b_src.push_back(8'hAB);
    drain();
    chk("sat_match", match_cnt, 15);
    chk("sat_mismatch", mismatch_cnt, 1);
    chk("sat_first_idx", first_mis_idx, 4);

    // Mid-stream reset with two words buffered on A.
    do_clear();
    b_en = 1'b0;
    a_src = '{8'h55, 8'h66};
    repeat (3) cyc();
    do_reset();
    b_en = 1'b1;
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_match", match_cnt, 0);
    chk("mrst_mismatch", mismatch_cnt, 0);
    chk("mrst_a_ready", a_ready, 1);
    chk("mrst_first_vld", first_mis_vld, 0);
    a_src = '{8'h07, 8'h08}; b_src = '{8'h07, 8'h09};
    drain();
    chk("mrst_first_idx", first_mis_idx, 1);
    chk("mrst_match2", match_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eq_stream_checker.md
EQ_STREAM_CHECKER -- requirements
Module: eq_stream_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, compared word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, per-side input FIFO depth in words (power of two, >=2).
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters and the pair index.
REQ-004 SHALL use one clock and a synchronous, active-high reset: ports clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 a_data / a_valid / a_ready  in / in / out  WIDTH / 1 / 1  stream A, valid/ready handshake.
REQ-008 b_data / b_valid / b_ready  in / in / out  WIDTH / 1 / 1  stream B, valid/ready handshake.
REQ-009 stop_en  input  1  1 = halt at first mismatch.
REQ-010 clear  input  1  one-cycle pulse: zero the statistics and leave HALT.
REQ-011 res_valid / res_ready / res_eq  out / in / out  1 / 1 / 1  per-pair result stream; res_eq=1 means the words are equal.
REQ-012 match_cnt, mismatch_cnt  output  CNT_W  saturating counts of pairs compared.
REQ-013 first_mis_vld / first_mis_idx  output  1 / CNT_W  sticky mismatch flag and the 0-based pair index of the first mismatch.
REQ-014 halted  output  1  high while the FSM is in HALT.

Function
REQ-015 Each side SHALL buffer words in its own DEPTH-entry FIFO; a_ready = !fullA && state==RUN (same rule for B).
REQ-016 A word SHALL be accepted on the rising edge where valid&&ready; A and B are independent and may skew by up to DEPTH words.
REQ-017 A pair SHALL be popped when both FIFOs are non-empty, state==RUN, and (!res_valid || res_ready).
REQ-018 The pop SHALL register res_eq = (A_head == B_head) over all WIDTH bits (masked per REQ-029) and set res_valid.
REQ-019 Latency: when the later word of a pair is accepted on edge k with empty FIFOs and no stall, res_valid SHALL be 1 after edge k+1.
REQ-020 res_valid SHALL stay high with res_eq stable until res_ready; throughput is one pair per cycle.
REQ-021 On each pop, match_cnt or mismatch_cnt SHALL increment and saturate at 2^CNT_W-1; the pair index SHALL increment and wrap modulo 2^CNT_W.
REQ-022 On the first mismatch after reset or clear, first_mis_vld SHALL be set and first_mis_idx SHALL capture the pair index; later mismatches SHALL not change them.
REQ-023 FSM states SHALL be RUN and HALT; RUN->HALT on a mismatch pop while stop_en=1; HALT->RUN on clear only.
REQ-024 In HALT, a_ready=b_ready=0 and no pops SHALL occur; FIFO contents and the pending result SHALL be retained.
REQ-025 clear SHALL zero the counters, the pair index and first_mis_*, and move to RUN; FIFOs and the result register are unaffected.
REQ-026 Simultaneous clear and pop: the pop SHALL occur, but the statistics SHALL be zeroed (clear wins), and the FSM SHALL stay in or enter RUN.
REQ-027 A push into a FIFO on the same edge as a pop from it SHALL be legal when the FIFO is full before the edge only if a_ready was high; no overflow or underflow SHALL be possible.

Reset
REQ-028 rst SHALL empty both FIFOs and set res_valid=0, res_eq=0, all counters 0, first_mis_vld=0, first_mis_idx=0, state RUN, halted=0; a_ready=b_ready=1 in the first cycle after reset, and a mid-stream reset SHALL discard all in-flight words.

Configuration
REQ-029 Macro EQ_STREAM_CHECKER_MASK_EN: when defined, it adds input cmp_mask[WIDTH-1:0], and only bits with mask=1 are compared (mask all-zero = always equal). When undefined, there is no port and all bits are compared.

Structure
REQ-030 The shared package eq_pkg SHALL hold typedef eq_state_t {RUN, HALT} and the default-parameter constants.
REQ-031 The FIFO SHALL be a sub-module eq_sync_fifo (WIDTH, DEPTH, synchronous reset), instantiated twice.

Verification
REQ-032 A: 5,9,3; B: 5,9,3 with no stall -> res_eq 1,1,1; match_cnt=3; mismatch_cnt=0; first_mis_vld=0; res_valid 1 after edge k+1.
REQ-033 A: 1,2,3; B: 1,7,3 with stop_en=1 -> second result res_eq=0; first_mis_idx=1; halted=1; a_ready=b_ready=0; third pair held until clear, then res_eq=1.
REQ-034 A runs DEPTH+2 words ahead of B -> a_ready drops after DEPTH words are buffered; no words lost; all results are equal once B catches up.
REQ-035 res_ready=0 for 10 cycles during a stream -> res_valid and res_eq stable; both FIFOs fill; a_ready=b_ready=0; stream resumes cleanly.
REQ-036 CNT_W=4, 20 equal pairs -> match_cnt saturates at 15; the pair index wraps to 4.
REQ-037 rst asserted mid-stream with 2 words buffered -> next cycle all outputs at reset values; subsequent pairs start at index 0.
